decode_ctrl_stage: RTL and testbench

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

---
 rtl/decode_ctrl_pkg.sv | 48 ++++
 rtl/decode_ctrl_comb.sv | 56 +++++
 rtl/decode_ctrl_stage.sv | 141 ++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ctrl_pkg.sv
// Shared definitions for the decode/control stage: opcode map, field positions
// and the control bundle produced by the combinational decoder.
package decode_ctrl_pkg;

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_J    = 5'b00001;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SETX = 5'b10101;
   localparam logic [4:0] OP_BEX  = 5'b10110;

   localparam int OPC_MSB   = 31;
   localparam int RD_LSB    = 22;
   localparam int RS_LSB    = 17;
   localparam int RT_LSB    = 12;
   localparam int SHAMT_LSB = 7;
   localparam int ALUOP_LSB = 2;
   localparam int FUNC_W    = 5;
   localparam int TARGET_W  = 27;

   typedef struct packed {
      logic is_alu;
      logic is_addi;
      logic is_sw;
      logic is_lw;
      logic is_j;
      logic is_bne;
      logic is_jal;
      logic is_jr;
      logic is_blt;
      logic is_setx;
      logic is_bex;
      logic illegal;
      logic dmwe;
      logic rwe;
      logic rwd;
      logic rdst;
      logic aluinb;
      logic [FUNC_W-1:0] alu_op;
      logic [FUNC_W-1:0] shamt;
   } ctrl_t;

endpackage

// File: rtl/decode_ctrl_comb.sv
// Pure combinational instruction decoder: opcode to control bundle plus the
// register, immediate and jump-target fields.
module decode_ctrl_comb
   import decode_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 5,
   parameter int REG_AW   = 5,
   parameter int IMM_W    = 17
)(
   input  logic [31:0]         insn,
   output ctrl_t               ctrl,
   output logic [REG_AW-1:0]   rd,
   output logic [REG_AW-1:0]   rs,
   output logic [REG_AW-1:0]   rt,
   output logic [31:0]         imm_sx,
   output logic [TARGET_W-1:0] target
);

   logic [OPCODE_W-1:0] opc;

   assign opc    = insn[OPC_MSB -: OPCODE_W];
   assign rd     = insn[RD_LSB +: REG_AW];
   assign rs     = insn[RS_LSB +: REG_AW];
   assign rt     = insn[RT_LSB +: REG_AW];
   assign imm_sx = {{(32-IMM_W){insn[IMM_W-1]}}, insn[IMM_W-1:0]};
   assign target = insn[TARGET_W-1:0];

   always_comb begin
      ctrl = '0;
      case (opc)
         OP_ALU:  ctrl.is_alu  = 1'b1;
         OP_J:    ctrl.is_j    = 1'b1;
         OP_BNE:  ctrl.is_bne  = 1'b1;
         OP_JAL:  ctrl.is_jal  = 1'b1;
         OP_JR:   ctrl.is_jr   = 1'b1;
         OP_ADDI: ctrl.is_addi = 1'b1;
         OP_BLT:  ctrl.is_blt  = 1'b1;
         OP_SW:   ctrl.is_sw   = 1'b1;
         OP_LW:   ctrl.is_lw   = 1'b1;
         OP_SETX: ctrl.is_setx = 1'b1;
         OP_BEX:  ctrl.is_bex  = 1'b1;
         default: ctrl.illegal = 1'b1;
      endcase
      // An unknown opcode raises only the illegal flag; Rdst stays low too.
      ctrl.dmwe   = ctrl.is_sw;
      ctrl.rwe    = ctrl.is_alu | ctrl.is_addi | ctrl.is_lw | ctrl.is_jal | ctrl.is_setx;
      ctrl.rwd    = ctrl.is_lw;
      ctrl.rdst   = ~ctrl.is_alu & ~ctrl.illegal;
      ctrl.aluinb = ctrl.is_addi | ctrl.is_sw | ctrl.is_lw;
      if (ctrl.is_alu) begin
         ctrl.alu_op = insn[ALUOP_LSB +: FUNC_W];
         ctrl.shamt  = insn[SHAMT_LSB +: FUNC_W];
      end
   end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode pipeline stage: registers the decoded bundle, stalls on load-use
// hazards against the held lw, and counts the bubbles those stalls create.
module decode_ctrl_stage
   import decode_ctrl_pkg::*;
#(
   parameter int OPCODE_W  = 5,
   parameter int REG_AW    = 5,
   parameter int IMM_W     = 17,
   parameter bit HAZARD_EN = 1'b1
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         insn,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                is_alu,
   output logic                is_addi,
   output logic                is_sw,
   output logic                is_lw,
   output logic                is_j,
   output logic                is_bne,
   output logic                is_jal,
   output logic                is_jr,
   output logic                is_blt,
   output logic                is_setx,
   output logic                is_bex,
   output logic                illegal,
   output logic                DMwe,
   output logic                Rwe,
   output logic                Rwd,
   output logic                Rdst,
   output logic                ALUinB,
   output logic [REG_AW-1:0]   rd,
   output logic [REG_AW-1:0]   rs,
   output logic [REG_AW-1:0]   rt,
   output logic [4:0]          alu_op,
   output logic [4:0]          shamt,
   output logic [31:0]         imm_sx,
   output logic [TARGET_W-1:0] target,
   output logic [15:0]         stall_cnt
);

   ctrl_t                dec;
   ctrl_t                q_ctrl;
   logic [REG_AW-1:0]    dec_rd, dec_rs, dec_rt;
   logic [31:0]          dec_imm;
   logic [TARGET_W-1:0]  dec_target;
   logic                 src_rs, src_rt, src_rd, reads_out_rd, hazard, accept;

   decode_ctrl_comb #(
      .OPCODE_W (OPCODE_W),
      .REG_AW   (REG_AW),
      .IMM_W    (IMM_W)
   ) u_comb (
      .insn   (insn),
      .ctrl   (dec),
      .rd     (dec_rd),
      .rs     (dec_rs),
      .rt     (dec_rt),
      .imm_sx (dec_imm),
      .target (dec_target)
   );

   // Load-use: the incoming instruction reads the register the held lw writes.
   assign src_rs = dec.is_alu | dec.is_addi | dec.is_lw | dec.is_sw | dec.is_bne | dec.is_blt;
   assign src_rt = dec.is_alu;
   assign src_rd = dec.is_sw | dec.is_bne | dec.is_blt | dec.is_jr;
   assign reads_out_rd = (src_rs && (dec_rs == rd)) || (src_rt && (dec_rt == rd)) ||
                         (src_rd && (dec_rd == rd));
   assign hazard = HAZARD_EN && out_valid && q_ctrl.is_lw && (rd != '0) && in_valid && reads_out_rd;

   // Handshake: a beat moves on either side only when valid and ready are both
   // high at a rising edge; valid never depends on ready, and a presented
   // output bundle is held unchanged until it is taken.
   assign in_ready = ~reset & (~out_valid | out_ready) & ~hazard & ~flush;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         q_ctrl    <= '0;
         rd        <= '0;
         rs        <= '0;
         rt        <= '0;
         imm_sx    <= '0;
         target    <= '0;
         stall_cnt <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         q_ctrl    <= '0;
         rd        <= '0;
         rs        <= '0;
         rt        <= '0;
         imm_sx    <= '0;
         target    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         q_ctrl    <= dec;
         rd        <= dec_rd;
         rs        <= dec_rs;
         rt        <= dec_rt;
         imm_sx    <= dec_imm;
         target    <= dec_target;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         q_ctrl    <= '0;
         rd        <= '0;
         rs        <= '0;
         rt        <= '0;
         imm_sx    <= '0;
         target    <= '0;
         // The lw leaving under a hazard guarantees the next cycle is a bubble.
         if (hazard && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign is_alu  = q_ctrl.is_alu;
   assign is_addi = q_ctrl.is_addi;
   assign is_sw   = q_ctrl.is_sw;
   assign is_lw   = q_ctrl.is_lw;
   assign is_j    = q_ctrl.is_j;
   assign is_bne  = q_ctrl.is_bne;
   assign is_jal  = q_ctrl.is_jal;
   assign is_jr   = q_ctrl.is_jr;
   assign is_blt  = q_ctrl.is_blt;
   assign is_setx = q_ctrl.is_setx;
   assign is_bex  = q_ctrl.is_bex;
   assign illegal = q_ctrl.illegal;
   assign DMwe    = q_ctrl.dmwe;
   assign Rwe     = q_ctrl.rwe;
   assign Rwd     = q_ctrl.rwd;
   assign Rdst    = q_ctrl.rdst;
   assign ALUinB  = q_ctrl.aluinb;
   assign alu_op  = q_ctrl.alu_op;
   assign shamt   = q_ctrl.shamt;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: directed scenarios plus a randomized run scored
// against a table-driven decode model and an expected-bundle queue.
module tb_decode_ctrl_stage;

   typedef struct packed {
      logic [10:0] flags;   // index = position in OPS below
      logic        illegal;
      logic        dmwe, rwe, rwd, rdst, aluinb;
      logic [4:0]  rd, rs, rt, alu_op, shamt;
      logic [31:0] imm;
      logic [26:0] target;
   } exp_t;

   localparam int         OPS  [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};
   localparam logic [4:0] POOL [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                                        5'd7, 5'd8, 5'd21, 5'd22, 5'd9, 5'd31};

   logic        clock = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] insn;
   logic        in_ready, out_valid;
   logic        is_alu, is_addi, is_sw, is_lw, is_j, is_bne, is_jal, is_jr, is_blt, is_setx, is_bex;
   logic        illegal, DMwe, Rwe, Rwd, Rdst, ALUinB;
   logic [4:0]  rd, rs, rt, alu_op, shamt;
   logic [31:0] imm_sx;
   logic [26:0] target;
   logic [15:0] stall_cnt;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   always #5 clock = ~clock;

   decode_ctrl_stage dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .insn(insn),
      .out_valid(out_valid), .out_ready(out_ready),
      .is_alu(is_alu), .is_addi(is_addi), .is_sw(is_sw), .is_lw(is_lw), .is_j(is_j),
      .is_bne(is_bne), .is_jal(is_jal), .is_jr(is_jr), .is_blt(is_blt),
      .is_setx(is_setx), .is_bex(is_bex), .illegal(illegal),
      .DMwe(DMwe), .Rwe(Rwe), .Rwd(Rwd), .Rdst(Rdst), .ALUinB(ALUinB),
      .rd(rd), .rs(rs), .rt(rt), .alu_op(alu_op), .shamt(shamt),
      .imm_sx(imm_sx), .target(target), .stall_cnt(stall_cnt)
   );

   // ---------------- reference model ----------------
   function automatic int op_index(input logic [31:0] w);
      int k = -1;
      for (int i = 0; i < 11; i++)
         if (int'(w[31:27]) == OPS[i]) k = i;
      return k;
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t e = '0;
      int   k = op_index(w);
      if (k < 0) e.illegal = 1'b1;
      else       e.flags[k] = 1'b1;
      e.dmwe   = (k == 7);
      e.rwe    = (k inside {0, 3, 5, 8, 9});
      e.rwd    = (k == 8);
      e.rdst   = (k > 0);
      e.aluinb = (k inside {5, 7, 8});
      e.rd     = w[26:22];
      e.rs     = w[21:17];
      e.rt     = w[16:12];
      e.alu_op = (k == 0) ? w[6:2]  : 5'd0;
      e.shamt  = (k == 0) ? w[11:7] : 5'd0;
      e.imm    = {15'd0, w[16:0]} - (w[16] ? 32'h0002_0000 : 32'h0);
      e.target = w[26:0];
      return e;
   endfunction

   function automatic logic reads(input logic [31:0] w, input logic [4:0] r);
      int k = op_index(w);
      return ((k inside {0, 2, 5, 6, 7, 8}) && (w[21:17] == r)) ||
             ((k == 0) && (w[16:12] == r)) ||
             ((k inside {2, 4, 6, 7}) && (w[26:22] == r));
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o.flags   = {is_bex, is_setx, is_lw, is_sw, is_blt, is_addi, is_jr, is_jal, is_bne, is_j, is_alu};
      o.illegal = illegal;
      o.dmwe    = DMwe;
      o.rwe     = Rwe;
      o.rwd     = Rwd;
      o.rdst    = Rdst;
      o.aluinb  = ALUinB;
      o.rd      = rd;
      o.rs      = rs;
      o.rt      = rt;
      o.alu_op  = alu_op;
      o.shamt   = shamt;
      o.imm     = imm_sx;
      o.target  = target;
      return o;
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] op, d, s, t, sh, fn);
      return {op, d, s, t, sh, fn, 2'b00};
   endfunction

   function automatic logic [31:0] enc_i(input logic [4:0] op, d, s, input logic [16:0] imm);
      return {op, d, s, imm};
   endfunction

   function automatic logic [31:0] rand_insn();
      logic [31:0] w = $urandom;
      w[31:27] = POOL[$urandom_range(0, 12)];
      w[26:22] = 5'($urandom_range(0, 3));
      w[21:17] = 5'($urandom_range(0, 3));
      w[16:12] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
      in_valid  = v;
      insn      = w;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #2;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
      checks++; if (observe() !== exp_t'(0)) begin errors++; $display("FAIL reset_bundle got %h want 0", observe()); end
      @(posedge clock);
      #1 reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_addi();
      apply_reset();
      drive(1'b1, enc_i(5'd5, 5'd3, 5'd1, -17'sd5), 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
      checks++; if ({is_addi, Rwe, ALUinB, Rdst, is_alu} !== 5'b11110) begin errors++; $display("FAIL addi_ctrl got %b want 11110", {is_addi, Rwe, ALUinB, Rdst, is_alu}); end
      checks++; if (imm_sx !== 32'hFFFF_FFFB) begin errors++; $display("FAIL addi_imm got %h want fffffffb", imm_sx); end
      checks++; if ({rd, rs} !== {5'd3, 5'd1}) begin errors++; $display("FAIL addi_regs got rd=%0d rs=%0d want 3 1", rd, rs); end
      tick();
      checks++; if (out_valid !== 1'b0 || observe() !== exp_t'(0)) begin errors++; $display("FAIL addi_drain got v=%b bundle=%h want 0 0", out_valid, observe()); end
   endtask

   task automatic test_load_use();
      apply_reset();
      drive(1'b1, enc_i(5'd8, 5'd4, 5'd1, 17'd0), 1'b1, 1'b0);
      tick();
      drive(1'b1, enc_r(5'd0, 5'd5, 5'd4, 5'd2, 5'd0, 5'd0), 1'b1, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_hazard_ready got %b want 0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b want 0", out_valid); end
      checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1 || is_alu !== 1'b1 || {rd, rs, rt} !== {5'd5, 5'd4, 5'd2}) begin
         errors++; $display("FAIL lu_add_out got v=%b alu=%b rd=%0d rs=%0d rt=%0d want 1 1 5 4 2", out_valid, is_alu, rd, rs, rt);
      end
      tick();
      checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_hold got %0d want 1", stall_cnt); end
   endtask

   task automatic test_lw_r0();
      apply_reset();
      drive(1'b1, enc_i(5'd8, 5'd0, 5'd1, 17'd8), 1'b1, 1'b0);
      tick();
      drive(1'b1, enc_r(5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b want 1", in_ready); end
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1 || is_alu !== 1'b1) begin errors++; $display("FAIL r0_no_bubble got v=%b alu=%b want 1 1", out_valid, is_alu); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL r0_stall_cnt got %0d want 0", stall_cnt); end
   endtask

   task automatic test_backpressure();
      exp_t        e_sw;
      logic [31:0] sw_w = enc_i(5'd7, 5'd6, 5'd2, 17'd12);
      e_sw = ref_decode(sw_w);
      apply_reset();
      drive(1'b1, sw_w, 1'b0, 1'b0);
      tick();
      drive(1'b1, enc_i(5'd5, 5'd1, 5'd1, 17'd1), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1 || observe() !== e_sw) begin errors++; $display("FAIL bp_hold[%0d] got v=%b %h want 1 %h", i, out_valid, observe(), e_sw); end
         tick();
      end
      checks++; if (DMwe !== 1'b1 || Rwe !== 1'b0) begin errors++; $display("FAIL bp_sw_ctrl got DMwe=%b Rwe=%b want 1 0", DMwe, Rwe); end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      apply_reset();
      drive(1'b1, enc_i(5'd8, 5'd4, 5'd1, 17'd0), 1'b1, 1'b0);
      tick();
      drive(1'b1, enc_r(5'd0, 5'd5, 5'd4, 5'd2, 5'd0, 5'd0), 1'b1, 1'b0);
      tick();
      drive(1'b1, enc_r(5'd0, 5'd5, 5'd4, 5'd2, 5'd0, 5'd0), 1'b1, 1'b1);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_a got %b want 0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_a got v=%b cnt=%0d want 0 1", out_valid, stall_cnt); end
      drive(1'b1, enc_i(5'd5, 5'd2, 5'd3, 17'd7), 1'b1, 1'b0);
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b want 1", out_valid); end
      drive(1'b1, enc_i(5'd3, 5'd31, 5'd0, 17'd100), 1'b1, 1'b1);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_b got %b want 0", in_ready); end
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0 || observe() !== exp_t'(0)) begin errors++; $display("FAIL flush_kill got v=%b %h want 0 0", out_valid, observe()); end
      checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_keep_cnt got %0d want 1", stall_cnt); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %b want 0", out_valid); end
   endtask

   task automatic test_illegal();
      apply_reset();
      drive(1'b1, enc_r(5'd31, 5'd5, 5'd6, 5'd7, 5'd3, 5'd9), 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if ({out_valid, illegal, DMwe, Rwe} !== 4'b1100) begin errors++; $display("FAIL illegal got v/ill/DMwe/Rwe=%b want 1100", {out_valid, illegal, DMwe, Rwe}); end
      checks++; if (observe().flags !== 11'd0 || alu_op !== 5'd0) begin errors++; $display("FAIL illegal_flags got %h alu_op=%0d want 0 0", observe().flags, alu_op); end
   endtask

   task automatic test_reset_mid_stall();
      apply_reset();
      drive(1'b1, enc_i(5'd8, 5'd4, 5'd1, 17'd0), 1'b1, 1'b0);
      tick();
      drive(1'b1, enc_r(5'd0, 5'd5, 5'd4, 5'd2, 5'd0, 5'd0), 1'b1, 1'b0);
      tick();
      drive(1'b1, enc_i(5'd8, 5'd6, 5'd1, 17'd4), 1'b1, 1'b0);
      tick();
      drive(1'b1, enc_r(5'd0, 5'd7, 5'd6, 5'd6, 5'd0, 5'd0), 1'b0, 1'b0);
      tick();
      tick();
      checks++; if ({out_valid, is_lw, in_ready} !== 3'b110 || stall_cnt !== 16'd1) begin
         errors++; $display("FAIL stall_setup got v/lw/rdy=%b cnt=%0d want 110 1", {out_valid, is_lw, in_ready}, stall_cnt);
      end
      #2 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || stall_cnt !== 16'd0) begin
         errors++; $display("FAIL async_reset got v=%b rdy=%b cnt=%0d want 0 0 0", out_valid, in_ready, stall_cnt);
      end
      checks++; if (observe() !== exp_t'(0)) begin errors++; $display("FAIL async_reset_bundle got %h want 0", observe()); end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      @(posedge clock);
      #1 reset = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard got %b want 0", out_valid); end
   endtask

   task automatic test_random();
      exp_t        cur;
      logic        m_valid, m_haz, m_ready;
      logic [15:0] m_stall = 16'd0;
      apply_reset();
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) != 0, rand_insn(), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
         #1;
         m_valid = (exp_q.size() != 0);
         cur     = m_valid ? exp_q[0] : exp_t'(0);
         m_haz   = m_valid && cur.flags[8] && (cur.rd != 5'd0) && in_valid && reads(insn, cur.rd);
         m_ready = (!m_valid || out_ready) && !m_haz && !flush;
         checks++; if (in_ready !== m_ready) begin errors++; $display("FAIL rand_ready c=%0d got %b want %b", c, in_ready, m_ready); end
         if (flush) exp_q.delete();
         else begin
            if (m_valid && out_ready) begin
               void'(exp_q.pop_front());
               if (m_haz && m_stall != 16'hFFFF) m_stall++;
            end
            if (in_valid && m_ready) exp_q.push_back(ref_decode(insn));
         end
         tick();
         cur = (exp_q.size() != 0) ? exp_q[0] : exp_t'(0);
         checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid c=%0d got %b want %b", c, out_valid, exp_q.size() != 0); end
         checks++; if (observe() !== cur) begin errors++; $display("FAIL rand_bundle c=%0d got %h want %h", c, observe(), cur); end
         checks++; if (stall_cnt !== m_stall) begin errors++; $display("FAIL rand_stall c=%0d got %0d want %0d", c, stall_cnt, m_stall); end
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load_use();
      test_lw_r0();
      test_backpressure();
      test_flush();
      test_illegal();
      test_reset_mid_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
